// File: rtl/fb_scanout_reader.sv
// Frame-buffer scanout reader: streams FB_WORDS RAM words from BASE_ADDR into a
// show-ahead prefetch FIFO and presents them to the pixel pipeline as valid/ready.
module fb_scanout_reader #(
  parameter int FB_WORDS   = 76800,
  parameter int BASE_ADDR  = 0,
  parameter int ADDR_W     = 17,
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              frame_start,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_chipselect,
  output logic              mem_clken,
  output logic              mem_write,
  output logic [3:0]        mem_byteenable,
  input  logic [DATA_W-1:0] mem_readdata,
  output logic [DATA_W-1:0] pix_data,
  output logic              pix_valid,
  input  logic              pix_ready,
  output logic              frame_done,
  output logic              underflow,
  output logic [1:0]        dbg_state
);
  localparam int IW = $clog2(FB_WORDS + 1);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {IDLE = 2'd0, FETCH = 2'd1, DRAIN = 2'd2} state_t;

  state_t            state_q, state_d;
  logic [IW-1:0]     issue_cnt_q, issue_cnt_d;
  logic [ADDR_W-1:0] next_addr_q, next_addr_d;
  logic [ADDR_W-1:0] mem_address_q, mem_address_d;
  logic              cs_q, cs_d;
  logic              pend_q, pend_d;
  logic [DATA_W-1:0] fifo_mem_q [FIFO_DEPTH];
  logic [DATA_W-1:0] fifo_mem_d [FIFO_DEPTH];
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              frame_done_q, frame_done_d;
  logic              underflow_q, underflow_d;
  logic              push, pop, credit_ok, active;

  // Handshake: a word transfers on any cycle where pix_valid && pix_ready are both
  // high; pix_valid never drops while a word is waiting, and pix_data holds the
  // FIFO head stable until it is taken. A frame_start cycle never transfers.
  always_comb begin
    active    = (state_q == FETCH) || (state_q == DRAIN);
    push      = pend_q && !frame_start;
    pop       = (count_q != '0) && pix_ready && !frame_start;
    // cs_q and pend_q are reads already committed to a FIFO slot
    credit_ok = ({1'b0, count_q} + (CW+1)'(cs_q) + (CW+1)'(pend_q))
                < (CW+1)'(FIFO_DEPTH);

    state_d       = state_q;
    issue_cnt_d   = issue_cnt_q;
    next_addr_d   = next_addr_q;
    mem_address_d = mem_address_q;
    cs_d          = 1'b0;
    pend_d        = cs_q && !frame_start;
    fifo_mem_d    = fifo_mem_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    count_d       = count_q;
    frame_done_d  = pop && (state_q == DRAIN) && (count_q == CW'(1)) && !cs_q && !pend_q;
    underflow_d   = underflow_q || (active && pix_ready && (count_q == '0));

    if (push) begin
      fifo_mem_d[wr_ptr_q] = mem_readdata;
      wr_ptr_d             = wr_ptr_q + PW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    case (state_q)
      IDLE: begin
      end
      FETCH: begin
        if (enable && credit_ok) begin
          cs_d          = 1'b1;
          mem_address_d = next_addr_q;
          next_addr_d   = next_addr_q + ADDR_W'(1);
          issue_cnt_d   = issue_cnt_q + IW'(1);
          if (issue_cnt_q == IW'(FB_WORDS - 1)) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if ((count_q == '0) && !cs_q && !pend_q) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Restart wins over everything: in-flight returns are dropped via pend_d/push.
    if (frame_start) begin
      state_d     = FETCH;
      issue_cnt_d = '0;
      next_addr_d = ADDR_W'(BASE_ADDR);
      cs_d        = 1'b0;
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      count_d     = '0;
      underflow_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= IDLE;
      issue_cnt_q   <= '0;
      next_addr_q   <= ADDR_W'(BASE_ADDR);
      mem_address_q <= ADDR_W'(BASE_ADDR);
      cs_q          <= 1'b0;
      pend_q        <= 1'b0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      frame_done_q  <= 1'b0;
      underflow_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      issue_cnt_q   <= issue_cnt_d;
      next_addr_q   <= next_addr_d;
      mem_address_q <= mem_address_d;
      cs_q          <= cs_d;
      pend_q        <= pend_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      frame_done_q  <= frame_done_d;
      underflow_q   <= underflow_d;
    end
  end

  // Storage needs no reset: entries are only visible once counted in.
  always_ff @(posedge clk) begin
    fifo_mem_q <= fifo_mem_d;
  end

  assign mem_address    = mem_address_q;
  assign mem_chipselect = cs_q;
  assign mem_clken      = 1'b1;
  assign mem_write      = 1'b0;
  assign mem_byteenable = 4'hF;
  assign pix_valid      = (count_q != '0);
  assign pix_data       = pix_valid ? fifo_mem_q[rd_ptr_q] : '0;
  assign frame_done     = frame_done_q;
  assign underflow      = underflow_q;
  assign dbg_state      = state_q;
endmodule

// File: tb/tb_fb_scanout_reader.sv
// Bench for fb_scanout_reader: RAM model, directed scenarios, random traffic, and a
// per-cycle compare against a frame-level model (expected word queue, sticky flag).
module tb_fb_scanout_reader;
  localparam int FB_WORDS = 16;
  localparam int BASE     = 'h100;
  localparam int ADDR_W   = 17;
  localparam int DATA_W   = 32;
  localparam int DEPTH    = 8;

  logic              clk = 1'b0;
  logic              reset, enable, frame_start, pix_ready;
  logic [ADDR_W-1:0] mem_address;
  logic              mem_chipselect, mem_clken, mem_write;
  logic [3:0]        mem_byteenable;
  logic [DATA_W-1:0] mem_readdata;
  logic [DATA_W-1:0] pix_data;
  logic              pix_valid, frame_done, underflow;
  logic [1:0]        dbg_state;

  fb_scanout_reader #(
    .FB_WORDS(FB_WORDS), .BASE_ADDR(BASE), .ADDR_W(ADDR_W),
    .DATA_W(DATA_W), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .frame_start(frame_start),
    .mem_address(mem_address), .mem_chipselect(mem_chipselect),
    .mem_clken(mem_clken), .mem_write(mem_write), .mem_byteenable(mem_byteenable),
    .mem_readdata(mem_readdata), .pix_data(pix_data), .pix_valid(pix_valid),
    .pix_ready(pix_ready), .frame_done(frame_done), .underflow(underflow),
    .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  function automatic logic [31:0] word_at(int a);
    return 32'(a) ^ 32'hA5A50000;
  endfunction

  // 1-cycle-latency RAM; garbage on non-read cycles exposes stray FIFO writes
  always @(posedge clk) begin
    if (mem_chipselect) mem_readdata <= word_at(int'(mem_address));
    else                mem_readdata <= $urandom;
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // scoreboard / model state
  logic [DATA_W-1:0] exp_q[$];
  bit          seen_reset = 0, chk_reset_vals = 0, chk_novalid = 0;
  bit          m_active = 0, m_uf = 0, m_done = 0;
  int          n_issued = 0, n_xfer = 0, done_cnt = 0, frame_xfers = 0;
  logic [31:0] first_data = '0, last_data = '0, last_cs_addr = '0;

  always @(negedge clk) begin
    bit          xfer, next_done;
    logic [31:0] w;
    next_done = 0;
    if (seen_reset) begin
      chk("mem_clken", mem_clken, 1);
      chk("mem_write", mem_write, 0);
      chk("mem_byteenable", mem_byteenable, 4'hF);
      if (chk_reset_vals) begin
        chk("rst_chipselect", mem_chipselect, 0);
        chk("rst_pix_valid", pix_valid, 0);
        chk("rst_pix_data", pix_data, 0);
        chk("rst_mem_address", mem_address, BASE);
      end
      if (chk_novalid) chk("valid_after_restart", pix_valid, 0);
      chk("frame_done", frame_done, m_done);
      chk("underflow", underflow, m_uf);
      if (exp_q.size() == 0) chk("no_extra_word", pix_valid, 0);
      if (mem_chipselect) begin
        chk("cs_in_frame", m_active && (n_issued < FB_WORDS), 1);
        chk("cs_addr", mem_address, BASE + n_issued);
        n_issued++;
        last_cs_addr = mem_address;
        chk("credit", (n_issued - n_xfer) <= DEPTH, 1);
      end
      xfer = reset && !frame_start && pix_valid && pix_ready;
      if (xfer && exp_q.size() != 0) begin
        w = exp_q.pop_front();
        chk("pix_data", pix_data, w);
        if (n_xfer == 0) first_data = pix_data;
        last_data = pix_data;
        n_xfer++;
        next_done = (exp_q.size() == 0);
      end
    end
    chk_reset_vals = 0;
    chk_novalid    = 0;
    if (!reset) begin
      seen_reset     = 1;
      chk_reset_vals = 1;
      exp_q.delete();
      m_active = 0; m_uf = 0; m_done = 0;
      n_issued = 0; n_xfer = 0;
    end else if (frame_start) begin
      exp_q.delete();
      for (int i = 0; i < FB_WORDS; i++) exp_q.push_back(word_at(BASE + i));
      m_active = 1; m_uf = 0; m_done = 0;
      n_issued = 0; n_xfer = 0;
      chk_novalid = 1;
    end else begin
      if (m_active && pix_ready && !pix_valid) m_uf = 1;
      if (m_done) m_active = 0;
      m_done = next_done;
      if (next_done) begin
        done_cnt++;
        frame_xfers = n_xfer;
      end
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_frame();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  task automatic wait_done(int budget, string name);
    int c0 = done_cnt;
    int n  = 0;
    while (done_cnt == c0 && n < budget) begin
      tick();
      n++;
    end
    chk(name, done_cnt != c0, 1);
    repeat (2) tick();
  endtask

  initial begin
    int n;
    reset = 1'b0; enable = 1'b1; frame_start = 1'b0; pix_ready = 1'b0;
    repeat (3) tick();
    reset = 1'b1;
    tick();
    chk("t1_chipselect", mem_chipselect, 0);
    chk("t1_pix_valid", pix_valid, 0);
    chk("t1_underflow", underflow, 0);
    chk("t1_frame_done", frame_done, 0);
    chk("t1_byteenable", mem_byteenable, 4'hF);

    // full frame, consumer always ready
    pix_ready = 1'b1;
    start_frame();
    wait_done(200, "t2_done");
    chk("t2_count", frame_xfers, 16);
    chk("t2_first", first_data, 32'hA5A50100);
    chk("t2_last", last_data, 32'hA5A5010F);
    chk("t2_last_addr", last_cs_addr, 32'h10F);
    tick();
    chk("t2_idle", dbg_state, 0);

    // backpressure: prefetch fills exactly the FIFO
    pix_ready = 1'b0;
    start_frame();
    repeat (30) tick();
    chk("t3_cs_count", n_issued, 8);
    chk("t3_last_addr", last_cs_addr, 32'h107);
    chk("t3_valid", pix_valid, 1);
    pix_ready = 1'b1;
    wait_done(200, "t3_done");
    chk("t3_count", frame_xfers, 16);

    // underflow, then cleared by the next frame_start
    pix_ready = 1'b1;
    start_frame();
    repeat (4) tick();
    chk("t4_underflow", underflow, 1);
    wait_done(200, "t4_done");
    chk("t4_count", frame_xfers, 16);
    start_frame();
    chk("t4_uf_clear", underflow, 0);
    wait_done(200, "t4_done2");

    // mid-frame restart after the 5th transfer
    start_frame();
    n = 0;
    while (n_xfer < 5 && n < 100) begin
      tick();
      n++;
    end
    chk("t5_reach5", n_xfer, 5);
    start_frame();
    wait_done(200, "t5_done");
    chk("t5_first", first_data, 32'hA5A50100);
    chk("t5_count", frame_xfers, 16);

    // reset with two reads outstanding
    pix_ready = 1'b0;
    start_frame();
    tick();
    tick();
    chk("t6_cs_inflight", mem_chipselect, 1);
    reset = 1'b0;
    tick();
    chk("t6_valid", pix_valid, 0);
    chk("t6_cs", mem_chipselect, 0);
    reset = 1'b1;
    repeat (6) tick();
    chk("t6_valid_stays", pix_valid, 0);
    pix_ready = 1'b1;
    start_frame();
    wait_done(200, "t6_done");
    chk("t6_count", frame_xfers, 16);
    chk("t6_first", first_data, 32'hA5A50100);

    // random traffic with enable gaps and occasional restarts
    for (int i = 0; i < 2500; i++) begin
      pix_ready   = ($urandom_range(0, 3) != 0);
      enable      = ($urandom_range(0, 4) != 0);
      frame_start = (!m_active && $urandom_range(0, 7) == 0) || ($urandom_range(0, 299) == 0);
      tick();
    end
    frame_start = 1'b0;
    enable      = 1'b1;
    pix_ready   = 1'b1;
    if (m_active) wait_done(400, "rand_tail_done");
    repeat (2) tick();
    chk("final_idle", dbg_state, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/fb_scanout_reader.md
Name: fb_scanout_reader

Overview:
- Downstream read stage for the 32-bit single-port on-chip frame-buffer RAM (17-bit word address, 1-cycle read latency).
- Walks the frame buffer linearly from BASE_ADDR once per frame and prefetches words into a small show-ahead FIFO.
- Presents one pixel word per valid/ready transfer to the VGA pixel pipeline.
- Flags underflow and signals end of frame.

Parameters:
- FB_WORDS, 76800, words per frame (320x240, one pixel per word).
- BASE_ADDR, 0, first word address of the frame.
- ADDR_W, 17, RAM word-address width.
- DATA_W, 32, RAM/pixel word width.
- FIFO_DEPTH, 8, prefetch FIFO entries; power of two, >=4.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-low reset.
- enable  in  1  permits issuing new RAM reads.
- frame_start  in  1  one-cycle pulse; restart scan at BASE_ADDR.
- mem_address  out  ADDR_W  RAM word address, registered.
- mem_chipselect  out  1  read strobe, registered; high = address valid this cycle.
- mem_clken  out  1  RAM clock enable; constant 1.
- mem_write  out  1  constant 0.
- mem_byteenable  out  4  constant 4'hF.
- mem_readdata  in  DATA_W  RAM read data; valid the cycle after a chipselect cycle.
- pix_data  out  DATA_W  FIFO head word.
- pix_valid  out  1  FIFO non-empty.
- pix_ready  in  1  consumer accepts pix_data when pix_valid && pix_ready.
- frame_done  out  1  one-cycle pulse when the last word of a frame is consumed.
- underflow  out  1  sticky; consumer was ready with the FIFO empty during an active frame.

Behaviour:
- Reset (reset==0 at posedge):
  - state=IDLE; FIFO empty; outstanding reads discarded.
  - mem_address=BASE_ADDR, mem_chipselect=0, pix_valid=0, pix_data=0, frame_done=0, underflow=0.
  - mem_clken=1, mem_write=0, mem_byteenable=4'hF at all times.
  - Reset mid-frame is identical; no RAM return is written after reset.
- Read timing:
  - Read issued in cycle N means mem_chipselect=1 with address A during cycle N.
  - mem_readdata for A is sampled in cycle N+1 and written to the FIFO at the end of N+1.
  - pix_valid can rise at N+2 at the earliest.
- Credit rule:
  - Issue a read only if enable=1, state==FETCH, and fifo_count + outstanding < FIFO_DEPTH.
  - outstanding = reads issued but not yet written, 0..2.
  - The FIFO never overflows; no read is ever dropped for lack of space.
- State machine:
  - IDLE: no reads. frame_start -> FETCH with issue counter=0 and next address=BASE_ADDR.
  - FETCH: issue reads per the credit rule; address increments by 1 per issued read. After read number FB_WORDS (address BASE_ADDR+FB_WORDS-1) -> DRAIN.
  - DRAIN: no new reads. When the FIFO is empty and outstanding=0 -> IDLE.
  - Address never wraps within a frame; the next frame starts from BASE_ADDR.
- Consumer side:
  - Show-ahead FIFO; pix_data = head entry while pix_valid=1.
  - Pop on pix_valid && pix_ready.
  - Simultaneous push and pop is allowed and leaves the count unchanged.
  - Pops are still served when enable=0.
- frame_done pulses the cycle after the transfer of word FB_WORDS-1, i.e. the final DRAIN pop.
- underflow:
  - Set when pix_ready=1 && pix_valid=0 while state is FETCH or DRAIN.
  - Held until frame_start or reset; never set in IDLE.
- frame_start in any state (FETCH/DRAIN mid-frame included):
  - Flush the FIFO; invalidate outstanding reads so their returns are dropped; clear underflow.
  - Restart FETCH at BASE_ADDR.
  - A pop requested in the same cycle is ignored.
  - pix_valid=0 the next cycle.
- enable=0 in FETCH: no new reads; outstanding reads complete normally. Issuing resumes when enable returns to 1.
- Counters: issue count is ceil(log2(FB_WORDS+1)) bits; FIFO count is log2(FIFO_DEPTH)+1 bits.

Test Plan:
- Reset values: hold reset=0 for 3 cycles, then release -> mem_chipselect=0, pix_valid=0, underflow=0, frame_done=0, mem_clken=1, mem_byteenable=4'hF, mem_write=0.
- Full frame, no backpressure: FB_WORDS=16, BASE_ADDR=0x100, RAM model word[a]=a ^ 0xA5A50000, frame_start with pix_ready=1 -> 16 transfers of 0xA5A50100..0xA5A5010F in order; one frame_done pulse; no address beyond 0x10F; returns to IDLE.
- Backpressure: FB_WORDS=16, pix_ready=0 after frame_start -> exactly 8 chipselect cycles (0x100..0x107) and FIFO full. Then pix_ready=1 -> reads resume, all 16 words in order, no loss or duplication.
- Underflow: FB_WORDS=16, pix_ready=1 from the same cycle as frame_start -> underflow=1 from the first empty-ready cycle; data order still correct. A new frame_start clears underflow.
- Mid-frame restart: assert frame_start after the 5th transfer while reads are in flight -> the next pix_data is word[0x100]; no stale word 0x105+ appears; exactly 16 transfers follow.
- Reset mid-operation: drive reset=0 during FETCH with outstanding=2 -> next cycle pix_valid=0, mem_chipselect=0, FIFO empty; no later FIFO write; a subsequent frame_start yields a clean frame.
